// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared FSM encoding and entry layout for the instruction fetch unit
package ifetch_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, DROP = 2'd2} state_t;
    localparam int ENTRY_W = 64;
    localparam logic [31:0] PC_INCR = 32'd4;
endpackage

// File: rtl/m_ifetch_fifo.sv
// m_ifetch_fifo: prefetch queue of {pc, instruction} entries with flush and registered head
module m_ifetch_fifo
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CW = $clog2(DEPTH) + 1
) (
    input  logic               w_clk,
    input  logic               w_rst_n,
    input  logic               w_push,
    input  logic [ENTRY_W-1:0] w_data,
    input  logic               w_pop,
    input  logic               w_flush,
    output logic [ENTRY_W-1:0] w_head,
    output logic [CW-1:0]      w_count
);
    localparam int AW = $clog2(DEPTH);
    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic do_push, do_pop;
    assign do_pop = w_pop && w_count != '0;
    assign do_push = w_push && (w_count < CW'(DEPTH) || do_pop);
    assign w_head = mem[rd_ptr];
    always_ff @(posedge w_clk or negedge w_rst_n)
        if (!w_rst_n) begin
            mem <= '{default: '0};
            wr_ptr <= '0;
            rd_ptr <= '0;
            w_count <= '0;
        end else if (w_flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            w_count <= '0;
        end else begin
            if (do_push) mem[wr_ptr] <= w_data;
            wr_ptr <= wr_ptr + AW'(do_push);
            rd_ptr <= rd_ptr + AW'(do_pop);
            w_count <= w_count + CW'(do_push) - CW'(do_pop);
        end
endmodule

// File: rtl/m_ifetch.sv
// m_ifetch: fetch FSM issuing one word request at a time into a prefetch queue, with redirect flush
module m_ifetch
    import ifetch_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        w_clk,
    input  logic        w_rst_n,
    output logic        w_imem_req,
    output logic [31:0] w_imem_addr,
    input  logic        w_imem_gnt,
    input  logic        w_imem_rvalid,
    input  logic [31:0] w_imem_rdata,
    input  logic        w_redirect,
    input  logic [31:0] w_redirect_pc,
    output logic        w_inst_valid,
    output logic [31:0] w_inst,
    output logic [31:0] w_inst_pc,
    input  logic        w_inst_ready
);
    localparam int CW = $clog2(DEPTH) + 1;
    state_t r_state, state_nxt;
    logic [31:0] r_fetch_pc, r_req_pc;
    logic [CW-1:0] count;
    logic [ENTRY_W-1:0] head;
    logic push;
    always_ff @(posedge w_clk or negedge w_rst_n)
        if (!w_rst_n) begin
            r_state <= IDLE;
            r_fetch_pc <= {RESET_PC[31:2], 2'b00};
            r_req_pc <= '0;
        end else begin
            r_state <= state_nxt;
            if (w_redirect) r_fetch_pc <= {w_redirect_pc[31:2], 2'b00};
            else if (push) r_fetch_pc <= r_req_pc + PC_INCR;
            if (w_imem_req && w_imem_gnt) r_req_pc <= r_fetch_pc;
        end
    // req is gated by reset so nothing is requested while the core is held
    always_comb begin
        state_nxt = r_state;
        w_imem_req = 1'b0;
        push = 1'b0;
        case (r_state)
            IDLE: begin
                w_imem_req = w_rst_n && count < CW'(DEPTH) && !w_redirect;
                state_nxt = (w_imem_req && w_imem_gnt) ? WAIT : IDLE;
            end
            WAIT: begin
                push = w_imem_rvalid && !w_redirect;
                state_nxt = w_imem_rvalid ? IDLE : (w_redirect ? DROP : WAIT);
            end
            DROP: state_nxt = w_imem_rvalid ? IDLE : DROP;
            default: state_nxt = IDLE;
        endcase
    end
    assign w_imem_addr = r_fetch_pc;
    assign w_inst_valid = count != '0;
    assign w_inst_pc = head[63:32];
    assign w_inst = head[31:0];
    m_ifetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .w_clk   (w_clk),
        .w_rst_n (w_rst_n),
        .w_push  (push),
        .w_data  ({r_req_pc, w_imem_rdata}),
        .w_pop   (w_inst_ready && w_inst_valid),
        .w_flush (w_redirect),
        .w_head  (head),
        .w_count (count)
    );
endmodule

// File: tb/tb_m_ifetch.sv
// tb_m_ifetch: directed checks of m_ifetch against a small variable-latency memory model
module tb_m_ifetch;
    localparam logic [31:0] K = 32'hC0DE_0000;
    logic        w_clk, w_rst_n;
    logic        w_imem_req, w_imem_gnt, w_imem_rvalid;
    logic [31:0] w_imem_addr, w_imem_rdata;
    logic        w_redirect, w_inst_valid, w_inst_ready;
    logic [31:0] w_redirect_pc, w_inst, w_inst_pc;
    int n_err = 0, n_chk = 0, cyc = 0, lat = 1, cd = 0;
    logic busy = 1'b0;
    logic [31:0] paddr;
    logic [31:0] gq[$], pq[$], dq[$];
    int gc[$], pc_c[$];

    m_ifetch #(.DEPTH(4), .RESET_PC(32'h0)) dut (
        .w_clk         (w_clk),
        .w_rst_n       (w_rst_n),
        .w_imem_req    (w_imem_req),
        .w_imem_addr   (w_imem_addr),
        .w_imem_gnt    (w_imem_gnt),
        .w_imem_rvalid (w_imem_rvalid),
        .w_imem_rdata  (w_imem_rdata),
        .w_redirect    (w_redirect),
        .w_redirect_pc (w_redirect_pc),
        .w_inst_valid  (w_inst_valid),
        .w_inst        (w_inst),
        .w_inst_pc     (w_inst_pc),
        .w_inst_ready  (w_inst_ready)
    );

    initial w_clk = 1'b0;
    always #5 w_clk = ~w_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timeout");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // sample at negedge, then advance one rising edge and update the memory model
    task automatic tick;
        logic s_req, s_gnt, s_rv, s_val, s_rdy;
        logic [31:0] s_addr, s_pc, s_inst;
        @(negedge w_clk);
        s_req = w_imem_req; s_gnt = w_imem_gnt; s_rv = w_imem_rvalid; s_addr = w_imem_addr;
        s_val = w_inst_valid; s_rdy = w_inst_ready; s_pc = w_inst_pc; s_inst = w_inst;
        @(posedge w_clk);
        #1;
        cyc++;
        if (!w_rst_n) begin
            busy = 1'b0;
            w_imem_rvalid = 1'b0;
        end else begin
            if (s_rv) begin
                assert (busy);
                busy = 1'b0;
            end
            if (s_req && s_gnt) begin
                busy = 1'b1; cd = lat; paddr = s_addr;
                gq.push_back(s_addr); gc.push_back(cyc);
            end
            if (s_val && s_rdy) begin
                pq.push_back(s_pc); dq.push_back(s_inst); pc_c.push_back(cyc);
            end
            w_imem_rvalid = busy && cd == 1;
            w_imem_rdata = (busy && cd == 1) ? paddr ^ K : 32'h0;
            if (busy && cd > 0) cd--;
        end
    endtask

    task automatic do_reset;
        w_rst_n = 1'b0;
        w_redirect = 1'b0;
        tick();
        tick();
        gq.delete(); pq.delete(); dq.delete(); gc.delete(); pc_c.delete();
        w_rst_n = 1'b1;
        #1;
    endtask

    initial begin
        w_rst_n = 1'b0; w_imem_gnt = 1'b0; w_imem_rvalid = 1'b0; w_imem_rdata = '0;
        w_redirect = 1'b0; w_redirect_pc = '0; w_inst_ready = 1'b0;
        #1;
        chk("rst req", 32'(w_imem_req), 0);
        chk("rst valid", 32'(w_inst_valid), 0);
        chk("rst inst", w_inst, 0);
        chk("rst inst_pc", w_inst_pc, 0);

        // streaming with single-cycle memory
        w_imem_gnt = 1'b1; w_inst_ready = 1'b1; lat = 1;
        do_reset();
        chk("first req", 32'(w_imem_req), 1);
        chk("first addr", w_imem_addr, 32'h0);
        repeat (9) tick();
        chk("stream grants", 32'(gq.size() >= 4), 1);
        chk("stream pops", 32'(pq.size() >= 4), 1);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("stream gaddr%0d", i), gq[i], 32'(4 * i));
            chk($sformatf("stream pc%0d", i), pq[i], 32'(4 * i));
            chk($sformatf("stream data%0d", i), dq[i], 32'(4 * i) ^ K);
        end
        chk("latency", 32'(pc_c[0] - gc[0]), 2);
        chk("throughput", 32'(pc_c[1] - pc_c[0]), 2);

        // fill with ready low, then drain
        w_inst_ready = 1'b0;
        do_reset();
        repeat (12) tick();
        chk("fill grants", 32'(gq.size()), 4);
        chk("full req", 32'(w_imem_req), 0);
        chk("full head pc", w_inst_pc, 32'h0);
        w_inst_ready = 1'b1;
        repeat (12) tick();
        for (int i = 0; i < 5; i++) chk($sformatf("drain pc%0d", i), pq[i], 32'(4 * i));
        chk("resume addr", gq[4], 32'h10);

        // redirect while waiting on a slow response
        w_inst_ready = 1'b0; lat = 1;
        do_reset();
        tick(); tick();
        lat = 3;
        tick();
        chk("pre-redir valid", 32'(w_inst_valid), 1);
        w_redirect = 1'b1; w_redirect_pc = 32'h103;
        tick();
        w_redirect = 1'b0;
        #1;
        chk("redir flush valid", 32'(w_inst_valid), 0);
        chk("drop req", 32'(w_imem_req), 0);
        tick(); tick();
        #1;
        chk("after drop req", 32'(w_imem_req), 1);
        chk("after drop addr", w_imem_addr, 32'h100);
        chk("drop discarded", 32'(w_inst_valid), 0);
        lat = 1;
        tick(); tick();
        chk("redir head pc", w_inst_pc, 32'h100);
        chk("redir head inst", w_inst, 32'h100 ^ K);

        // redirect coinciding with rvalid and a pop at count 2
        do_reset();
        repeat (5) tick();
        chk("cnt2 head", w_inst_pc, 32'h0);
        chk("cnt2 rvalid due", 32'(w_imem_rvalid), 1);
        w_redirect = 1'b1; w_redirect_pc = 32'h200; w_inst_ready = 1'b1;
        tick();
        w_redirect = 1'b0; w_inst_ready = 1'b0;
        #1;
        chk("coll valid", 32'(w_inst_valid), 0);
        chk("coll req", 32'(w_imem_req), 1);
        chk("coll addr", w_imem_addr, 32'h200);
        tick(); tick();
        chk("coll head pc", w_inst_pc, 32'h200);

        // grant withheld, redirect during the stall
        w_imem_gnt = 1'b0; w_inst_ready = 1'b1;
        do_reset();
        chk("stall c1 req", 32'(w_imem_req), 1);
        chk("stall c1 addr", w_imem_addr, 32'h0);
        tick();
        #1;
        chk("stall c2 req", 32'(w_imem_req), 1);
        chk("stall c2 addr", w_imem_addr, 32'h0);
        tick();
        w_redirect = 1'b1; w_redirect_pc = 32'h300;
        #1;
        chk("stall c3 req", 32'(w_imem_req), 0);
        tick();
        w_redirect = 1'b0;
        #1;
        chk("stall c4 req", 32'(w_imem_req), 1);
        chk("stall c4 addr", w_imem_addr, 32'h300);
        tick();
        chk("stall c5 addr", w_imem_addr, 32'h300);
        w_imem_gnt = 1'b1;
        tick();
        chk("stall grants", 32'(gq.size()), 1);
        chk("stall gaddr", gq[0], 32'h300);

        // address wrap at the top of memory
        do_reset();
        w_redirect = 1'b1; w_redirect_pc = 32'hFFFF_FFFC;
        #1;
        chk("wrap redir req", 32'(w_imem_req), 0);
        tick();
        w_redirect = 1'b0;
        repeat (4) tick();
        chk("wrap g0", gq[0], 32'hFFFF_FFFC);
        chk("wrap g1", gq[1], 32'h0);
        chk("wrap g1 present", 32'(gq.size() >= 2), 1);
        chk("wrap pc", pq[0], 32'hFFFF_FFFC);
        chk("wrap data", dq[0], 32'hFFFF_FFFC ^ K);

        // asynchronous reset in the middle of an outstanding request
        w_inst_ready = 1'b0; lat = 1;
        do_reset();
        tick(); tick();
        lat = 3;
        tick();
        chk("mid pre valid", 32'(w_inst_valid), 1);
        #2;
        w_rst_n = 1'b0;
        #1;
        chk("mid rst req", 32'(w_imem_req), 0);
        chk("mid rst valid", 32'(w_inst_valid), 0);
        chk("mid rst inst", w_inst, 0);
        chk("mid rst inst_pc", w_inst_pc, 0);
        tick();
        gq.delete();
        w_rst_n = 1'b1;
        lat = 1;
        #1;
        chk("restart req", 32'(w_imem_req), 1);
        chk("restart addr", w_imem_addr, 32'h0);
        tick(); tick();
        chk("restart head pc", w_inst_pc, 32'h0);
        chk("restart gaddr", gq[0], 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
